// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: load-size encodings and the
// buffered entry layout that is presented to the RegisterFile write port.
package wb_pkg;

    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

    // Entry data width; writeback_stage is built with DATA_W equal to this.
    localparam int WB_DATA_W = 32;

    typedef struct packed {
        logic                 writeEnable;
        logic [4:0]           regAddr;
        logic [WB_DATA_W-1:0] data;
    } wbEntry_t;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// Little-endian load extraction: selects the addressed halfword/byte of an
// aligned memory word and sign- or zero-extends it to the full data width.
module load_formatter
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] memReadData,
    input  logic [1:0]        byteOffset,
    input  logic [1:0]        loadSize,
    input  logic              loadUnsigned,
    output logic [DATA_W-1:0] loadData
);

    logic [15:0] halfSel;
    logic [7:0]  byteSel;

    always_comb begin
        halfSel = byteOffset[1] ? memReadData[31:16] : memReadData[15:0];
        case (byteOffset)
            2'd0:    byteSel = memReadData[7:0];
            2'd1:    byteSel = memReadData[15:8];
            2'd2:    byteSel = memReadData[23:16];
            default: byteSel = memReadData[31:24];
        endcase

        // Encoding 11 is not a legal size and falls through to a full word.
        case (loadSize)
            LS_HALF: loadData = {{(DATA_W-16){halfSel[15] & ~loadUnsigned}}, halfSel};
            LS_BYTE: loadData = {{(DATA_W-8){byteSel[7] & ~loadUnsigned}}, byteSel};
            default: loadData = memReadData;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: a DEPTH-entry FIFO of formatted results retiring one per
// cycle into the RegisterFile. Optional macro WB_FORWARD_EN adds Fwd* outputs.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic                       RegWriteIn,
    input  logic                       MemToReg,
    input  logic [1:0]                 LoadSize,
    input  logic                       LoadUnsigned,
    input  logic [4:0]                 WriteRegisterIn,
    input  logic [DATA_W-1:0]          ALUResult,
    input  logic [DATA_W-1:0]          MemReadData,
    input  logic                       Hold,
    input  logic                       Flush,
    output logic                       RegWrite,
    output logic [4:0]                 WriteRegister,
    output logic [DATA_W-1:0]          WriteData,
`ifdef WB_FORWARD_EN
    output logic                       FwdValid,
    output logic [4:0]                 FwdRegister,
    output logic [DATA_W-1:0]          FwdData,
`endif
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wbEntry_t          entries [DEPTH];
    wbEntry_t          newEntry;
    wbEntry_t          headEntry;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] loadData;
    logic              doPush;
    logic              doPop;

    load_formatter #(.DATA_W(DATA_W)) uFormatter (
        .memReadData (MemReadData),
        .byteOffset  (ALUResult[1:0]),
        .loadSize    (LoadSize),
        .loadUnsigned(LoadUnsigned),
        .loadData    (loadData)
    );

    // Register $0 is never written, so its entries carry a cleared write-enable.
    always_comb begin
        newEntry.writeEnable = RegWriteIn && (WriteRegisterIn != 5'd0);
        newEntry.regAddr     = WriteRegisterIn;
        newEntry.data        = MemToReg ? loadData : ALUResult;
    end

    // InValid/InReady: a result transfers on an edge where both are high and
    // Flush is low; InReady depends only on occupancy, never on InValid.
    assign InReady = (count < CNT_W'(DEPTH));
    assign doPush  = InValid && InReady && !Flush;
    assign doPop   = (count != '0) && !Hold && !Flush;

    assign headEntry     = entries[rdPtr];
    assign RegWrite      = (count != '0) && !Hold && headEntry.writeEnable;
    assign WriteRegister = headEntry.regAddr;
    assign WriteData     = headEntry.data;
    assign Count         = count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (Flush) begin
            count <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) begin
                entries[wrPtr] <= newEntry;
                wrPtr          <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the youngest writing entry wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = '0;
        FwdValid    = 1'b0;
        FwdRegister = '0;
        FwdData     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rdPtr + PTR_W'(i);
            if ((CNT_W'(i) < count) && entries[idx].writeEnable) begin
                FwdValid    = 1'b1;
                FwdRegister = entries[idx].regAddr;
                FwdData     = entries[idx].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus random
// traffic, with a scoreboard of expected write-port entries.
module tb_writeback_stage;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              InValid = 1'b0;
    logic              InReady;
    logic              RegWriteIn = 1'b0;
    logic              MemToReg = 1'b0;
    logic [1:0]        LoadSize = 2'b00;
    logic              LoadUnsigned = 1'b0;
    logic [4:0]        WriteRegisterIn = '0;
    logic [DATA_W-1:0] ALUResult = '0;
    logic [DATA_W-1:0] MemReadData = '0;
    logic              Hold = 1'b0;
    logic              Flush = 1'b0;
    logic              RegWrite;
    logic [4:0]        WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [1:0]        Count;
`ifdef WB_FORWARD_EN
    logic              FwdValid;
    logic [4:0]        FwdRegister;
    logic [DATA_W-1:0] FwdData;
`endif

    int checkCount = 0;
    int errorCount = 0;

    // Expected entries: {writeEnable, regAddr[4:0], data[31:0]}
    logic [37:0] exp_q[$];
    logic [31:0] rf [32] = '{default: '0};

    writeback_stage #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
        .RegWriteIn(RegWriteIn), .MemToReg(MemToReg), .LoadSize(LoadSize),
        .LoadUnsigned(LoadUnsigned), .WriteRegisterIn(WriteRegisterIn),
        .ALUResult(ALUResult), .MemReadData(MemReadData), .Hold(Hold),
        .Flush(Flush), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData),
`ifdef WB_FORWARD_EN
        .FwdValid(FwdValid), .FwdRegister(FwdRegister), .FwdData(FwdData),
`endif
        .Count(Count)
    );

    always #5 Clk = ~Clk;

    // Behavioural RegisterFile: commits whatever the write port presents.
    always @(posedge Clk) begin
        if (RegWrite) rf[WriteRegister] <= WriteData;
    end

    task automatic checkEq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] fmtModel(input logic m2r, input logic [1:0] ls, input logic lu,
                                             input logic [31:0] alu, input logic [31:0] mem);
        logic [31:0] sh;
        if (!m2r) return alu;
        case (ls)
            2'b01: begin
                sh = mem >> (alu[1] ? 16 : 0);
                return lu ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            2'b10: begin
                sh = mem >> (8 * int'(alu[1:0]));
                return lu ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            default: return mem;
        endcase
    endfunction

    task automatic setInputs(input logic we, input logic [4:0] rd, input logic m2r, input logic [1:0] ls,
                             input logic lu, input logic [31:0] alu, input logic [31:0] mem);
        RegWriteIn = we; WriteRegisterIn = rd; MemToReg = m2r; LoadSize = ls;
        LoadUnsigned = lu; ALUResult = alu; MemReadData = mem;
    endtask

    // Called just after a falling edge: drive, check, update model, advance one cycle.
    task automatic stepCycle(input logic v, input logic hold, input logic flush, input logic [31:0] expData);
        logic [37:0] head;
        logic [37:0] entry;
        bit accept, retire;
        InValid = v; Hold = hold; Flush = flush;
        #2;
        checkEq("count", 64'(Count), 64'(exp_q.size()));
        checkEq("in_ready", 64'(InReady), 64'(exp_q.size() < DEPTH));
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            checkEq("reg_write", 64'(RegWrite), 64'(head[37] && !hold));
            checkEq("write_register", 64'(WriteRegister), 64'(head[36:32]));
            checkEq("write_data", 64'(WriteData), 64'(head[31:0]));
        end else begin
            checkEq("reg_write_empty", 64'(RegWrite), 64'(0));
        end
        entry  = {RegWriteIn && (WriteRegisterIn != 5'd0), WriteRegisterIn, expData};
        accept = v && (exp_q.size() < DEPTH) && !flush;
        retire = (exp_q.size() > 0) && !hold && !flush;
        if (flush) exp_q.delete();
        else begin
            if (retire) void'(exp_q.pop_front());
            if (accept) exp_q.push_back(entry);
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic pushOp(input logic [4:0] rd, input logic m2r, input logic [1:0] ls, input logic lu,
                          input logic [31:0] alu, input logic [31:0] mem, input logic hold, input logic [31:0] expData);
        setInputs(1'b1, rd, m2r, ls, lu, alu, mem);
        stepCycle(1'b1, hold, 1'b0, expData);
    endtask

    task automatic idleOp(input logic hold);
        setInputs(1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        stepCycle(1'b0, hold, 1'b0, 32'h0);
    endtask

    initial begin
        logic v, we, m2r, lu, hold, flush;
        logic [1:0] ls;
        logic [4:0] rd;
        logic [31:0] alu, mem;

        // Clock/reset
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        checkEq("reset_reg_write", 64'(RegWrite), 64'(0));
        checkEq("reset_count", 64'(Count), 64'(0));
        checkEq("reset_in_ready", 64'(InReady), 64'(1));
        Reset_n = 1'b1;
        #2;
        checkEq("post_reset_write_data", 64'(WriteData), 64'(0));
        checkEq("post_reset_write_register", 64'(WriteRegister), 64'(0));
        @(negedge Clk);

        // ALU result straight through to reg 8
        pushOp(5'd8, 1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0, 1'b0, 32'h0000_0001);
        idleOp(1'b0);
        checkEq("rf_r8", 64'(rf[8]), 64'h1);

        // Load formatting: signed byte at offset 1, unsigned upper halfword
        pushOp(5'd3, 1'b1, 2'b10, 1'b0, 32'h0000_0001, 32'h8081_F2F3, 1'b0, 32'hFFFF_FFF2);
        pushOp(5'd4, 1'b1, 2'b01, 1'b1, 32'h0000_0002, 32'h8081_F2F3, 1'b0, 32'h0000_8081);
        pushOp(5'd5, 1'b1, 2'b11, 1'b0, 32'h0000_0003, 32'h8081_F2F3, 1'b0, 32'h8081_F2F3);
        pushOp(5'd6, 1'b1, 2'b01, 1'b0, 32'h0000_0000, 32'h8081_F2F3, 1'b0, 32'hFFFF_F2F3);
        idleOp(1'b0);
        idleOp(1'b0);
        checkEq("rf_r3", 64'(rf[3]), 64'hFFFF_FFF2);
        checkEq("rf_r4", 64'(rf[4]), 64'h0000_8081);

        // Hold: fill to DEPTH, third push refused, then drain in order
        pushOp(5'd9,  1'b0, 2'b00, 1'b0, 32'h99, 32'h0, 1'b1, 32'h99);
        pushOp(5'd10, 1'b0, 2'b00, 1'b0, 32'hAA, 32'h0, 1'b1, 32'hAA);
        pushOp(5'd11, 1'b0, 2'b00, 1'b0, 32'hBB, 32'h0, 1'b1, 32'hBB);
        idleOp(1'b0);
        idleOp(1'b0);
        idleOp(1'b0);
        checkEq("rf_r10", 64'(rf[10]), 64'hAA);
        checkEq("rf_r11_untouched", 64'(rf[11]), 64'h0);

        // $0 entry pops without a write
        pushOp(5'd0, 1'b0, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'hDEAD_BEEF);
        idleOp(1'b0);
        idleOp(1'b0);
        checkEq("rf_r0", 64'(rf[0]), 64'h0);

        // Flush while full under Hold, with a concurrent valid push
        pushOp(5'd20, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b1, 32'h20);
        pushOp(5'd21, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b1, 32'h21);
        setInputs(1'b1, 5'd22, 1'b0, 2'b00, 1'b0, 32'h22, 32'h0);
        stepCycle(1'b1, 1'b1, 1'b1, 32'h22);
        idleOp(1'b0);
        idleOp(1'b0);
        checkEq("rf_r20_flushed", 64'(rf[20]), 64'h0);
        checkEq("rf_r22_flushed", 64'(rf[22]), 64'h0);

        // Asynchronous reset mid-operation with two entries buffered
        pushOp(5'd13, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 32'h13);
        pushOp(5'd14, 1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 1'b1, 32'h14);
        setInputs(1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        InValid = 1'b0; Hold = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        checkEq("async_reset_reg_write", 64'(RegWrite), 64'(0));
        checkEq("async_reset_count", 64'(Count), 64'(0));
        checkEq("async_reset_in_ready", 64'(InReady), 64'(1));
        checkEq("async_reset_write_data", 64'(WriteData), 64'(0));
        exp_q.delete();
        @(negedge Clk);
        Reset_n = 1'b1;
        #2;
        checkEq("after_reset_reg_write", 64'(RegWrite), 64'(0));
        checkEq("after_reset_write_register", 64'(WriteRegister), 64'(0));
        checkEq("rf_r13_discarded", 64'(rf[13]), 64'h0);
        @(negedge Clk);
        pushOp(5'd12, 1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 1'b0, 32'h5);
        idleOp(1'b0);
        checkEq("rf_r12", 64'(rf[12]), 64'h5);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            v     = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            rd    = 5'($urandom_range(0, 31));
            m2r   = 1'($urandom_range(0, 1));
            ls    = 2'($urandom_range(0, 3));
            lu    = 1'($urandom_range(0, 1));
            alu   = 32'($urandom());
            mem   = 32'($urandom());
            hold  = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 19) == 0);
            setInputs(we, rd, m2r, ls, lu, alu, mem);
            stepCycle(v, hold, flush, fmtModel(m2r, ls, lu, alu, mem));
        end
        repeat (DEPTH + 1) idleOp(1'b0);
        checkEq("final_drain", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
